// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter
// Shares a single cache lookup port between NUM_REQ requesters. Requests are
// granted round-robin, and only one cache transaction is outstanding at a time.
// The granted requester gets a one-cycle response pulse. Saturating counters
// track completed reads, completed writes and hits.
//
// Ports
//   clk, reset     : clock; asynchronous active-high reset
//   req_valid/rw   : per-requester request valid and op (0 read, 1 write)
//   req_addr       : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready      : combinational accept strobe, only the winner's bit, only in IDLE
//   rsp_valid      : one-cycle completion pulse to the granted requester
//   rsp_hit        : hit flag, valid alongside rsp_valid
//   c_valid/rw/addr: cache request strobe with op and address held stable
//   c_ready        : cache accepts the request
//   c_done, c_hit  : cache lookup completion pulse and result
//   num_reads/num_writes/num_hits : saturating statistics
module cache_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic                      rsp_hit,
    output logic                      c_valid,
    output logic                      c_rw,
    output logic [ADDR_W-1:0]         c_addr,
    input  logic                      c_ready,
    input  logic                      c_done,
    input  logic                      c_hit,
    output logic [CNT_W-1:0]          num_reads,
    output logic [CNT_W-1:0]          num_writes,
    output logic [CNT_W-1:0]          num_hits
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       last_grant_q, last_grant_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rw_q, rw_d;
    logic                c_valid_q, c_valid_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic [CNT_W-1:0]    num_reads_q, num_reads_d;
    logic [CNT_W-1:0]    num_writes_q, num_writes_d;
    logic [CNT_W-1:0]    num_hits_q, num_hits_d;

    logic                found;
    logic [GW-1:0]       winner;
    logic [ADDR_W-1:0]   winner_addr;
    logic                winner_rw;

    // Round-robin search starting one past the last grant. The outer loop is the
    // priority offset, so the first match found is the highest priority one.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_valid[i] &&
                    (i == ((int'(last_grant_q) + k) % NUM_REQ))) begin
                    found  = 1'b1;
                    winner = GW'(i);
                end
            end
        end
    end

    always_comb begin
        winner_addr = '0;
        winner_rw   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(winner) == i) begin
                winner_addr = req_addr[i*ADDR_W +: ADDR_W];
                winner_rw   = req_rw[i];
            end
        end
    end

    // Gated with reset so that no accept is advertised while reset is held.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state_q == S_IDLE) && !reset && found &&
                           (int'(winner) == i);
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        rw_d         = rw_q;
        c_valid_d    = 1'b0;
        rsp_valid_d  = '0;
        rsp_hit_d    = 1'b0;
        num_reads_d  = num_reads_q;
        num_writes_d = num_writes_q;
        num_hits_d   = num_hits_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d   = winner;
                    addr_d    = winner_addr;
                    rw_d      = winner_rw;
                    c_valid_d = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (c_ready) begin
                    state_d = S_WAIT;
                end else begin
                    c_valid_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (c_done) begin
                    rsp_hit_d = c_hit;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        rsp_valid_d[i] = (int'(grant_q) == i);
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // rsp_hit_q holds the hit latched on c_done.
                if (rw_q) begin
                    if (num_writes_q != {CNT_W{1'b1}}) begin
                        num_writes_d = num_writes_q + CNT_W'(1);
                    end
                end else begin
                    if (num_reads_q != {CNT_W{1'b1}}) begin
                        num_reads_d = num_reads_q + CNT_W'(1);
                    end
                end
                if (rsp_hit_q && (num_hits_q != {CNT_W{1'b1}})) begin
                    num_hits_d = num_hits_q + CNT_W'(1);
                end
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            c_valid_q    <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_hit_q    <= 1'b0;
            num_reads_q  <= '0;
            num_writes_q <= '0;
            num_hits_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            c_valid_q    <= c_valid_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_hit_q    <= rsp_hit_d;
            num_reads_q  <= num_reads_d;
            num_writes_q <= num_writes_d;
            num_hits_q   <= num_hits_d;
        end
    end

    assign c_valid    = c_valid_q;
    assign c_rw       = rw_q;
    assign c_addr     = addr_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp_hit_q;
    assign num_reads  = num_reads_q;
    assign num_writes = num_writes_q;
    assign num_hits   = num_hits_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
module tb_cache_req_arbiter;

    localparam int N     = 2;
    localparam int AW    = 32;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_rw;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic            rsp_hit;
    logic            c_valid;
    logic            c_rw;
    logic [AW-1:0]   c_addr;
    logic            c_ready;
    logic            c_done;
    logic            c_hit;
    logic [CW-1:0]   num_reads;
    logic [CW-1:0]   num_writes;
    logic [CW-1:0]   num_hits;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_lg;
    int m_rd;
    int m_wr;
    int m_hit;

    cache_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .c_valid    (c_valid),
        .c_rw       (c_rw),
        .c_addr     (c_addr),
        .c_ready    (c_ready),
        .c_done     (c_done),
        .c_hit      (c_hit),
        .num_reads  (num_reads),
        .num_writes (num_writes),
        .num_hits   (num_hits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int lg, input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(lg + k) % N]) return (lg + k) % N;
        end
        return -1;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    task automatic chk_counts(input string tag);
        chk({tag, "_reads"},  num_reads,  m_rd);
        chk({tag, "_writes"}, num_writes, m_wr);
        chk({tag, "_hits"},   num_hits,   m_hit);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        req_rw    = '0;
        req_addr  = '0;
        c_ready   = 1'b0;
        c_done    = 1'b0;
        c_hit     = 1'b0;
        #1;
        chk("rst_c_valid", c_valid, 0);
        chk("rst_c_addr", c_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        m_lg = N - 1; m_rd = 0; m_wr = 0; m_hit = 0;
        chk_counts("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One complete transaction. want_g >= 0 forces the expected grant,
    // otherwise the round-robin model chooses it.
    task automatic run_txn(input logic [N-1:0] mask, input logic [N-1:0] rws,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input int stall, input int dly, input logic hit,
                           input bit noise, input int want_g);
        int g;
        logic [AW-1:0] ea;
        logic erw;
        g   = (want_g >= 0) ? want_g : rr_pick(m_lg, mask);
        ea  = (g == 1) ? a1 : a0;
        erw = rws[g];

        @(negedge clk);
        req_valid = mask;
        req_rw    = rws;
        req_addr  = {a1, a0};
        c_ready   = 1'b0;
        c_done    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        c_hit     = 1'($urandom_range(0, 1));
        #1;
        chk("idle_req_ready", req_ready, onehot(g));
        chk("idle_c_valid", c_valid, 0);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk_counts("idle");

        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            req_valid = mask & ~onehot(g);
            req_rw    = 2'($urandom);
            req_addr  = {$urandom, $urandom};
            c_ready   = (s == stall);
            c_done    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            chk("issue_c_valid", c_valid, 1);
            chk("issue_c_addr", c_addr, ea);
            chk("issue_c_rw", c_rw, erw);
            chk("issue_req_ready", req_ready, 0);
        end

        for (int d = 0; d <= dly; d++) begin
            @(negedge clk);
            c_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            c_done  = (d == dly);
            c_hit   = (d == dly) ? hit : 1'($urandom_range(0, 1));
            #1;
            chk("wait_c_valid", c_valid, 0);
            chk("wait_rsp_valid", rsp_valid, 0);
            chk("wait_req_ready", req_ready, 0);
        end

        @(negedge clk);
        c_ready = 1'b0;
        c_done  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        c_hit   = 1'($urandom_range(0, 1));
        #1;
        chk("resp_rsp_valid", rsp_valid, onehot(g));
        chk("resp_rsp_hit", rsp_hit, hit);
        chk("resp_c_valid", c_valid, 0);
        chk("resp_req_ready", req_ready, 0);

        m_lg = g;
        if (erw) m_wr = sat_inc(m_wr);
        else     m_rd = sat_inc(m_rd);
        if (hit) m_hit = sat_inc(m_hit);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        req_valid = '0;
        c_done    = 1'($urandom_range(0, 1));
        #1;
        chk("noreq_req_ready", req_ready, 0);
        @(negedge clk);
        c_done = 1'b0;
        #1;
        chk("noreq_c_valid", c_valid, 0);
        chk("noreq_rsp_valid", rsp_valid, 0);
        chk_counts("noreq");
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_rw    = '0;
        req_addr  = '0;
        c_ready   = 1'b0;
        c_done    = 1'b0;
        c_hit     = 1'b0;
        do_reset();

        // Single read hit, minimum latency
        run_txn(2'b01, 2'b00, 32'h0000_1040, 32'h0, 0, 0, 1'b1, 1'b0, 0);
        idle_cycle();
        chk("t2_reads", num_reads, 1);
        chk("t2_hits", num_hits, 1);

        // Reset while waiting on the cache
        @(negedge clk);
        req_valid = 2'b01; req_rw = 2'b00; req_addr = {32'h0, 32'hABCD_0000};
        @(negedge clk);
        req_valid = 2'b00; c_ready = 1'b1;
        #1;
        chk("t1_issue_c_valid", c_valid, 1);
        @(negedge clk);
        c_ready = 1'b0;
        #1;
        chk("t1_wait_c_valid", c_valid, 0);
        #1;
        reset = 1'b1; req_valid = 2'b11;
        #1;
        chk("t1_c_valid", c_valid, 0);
        chk("t1_rsp_valid", rsp_valid, 0);
        chk("t1_rsp_hit", rsp_hit, 0);
        chk("t1_req_ready", req_ready, 0);
        chk("t1_c_addr", c_addr, 0);
        chk("t1_c_rw", c_rw, 0);
        m_lg = N - 1; m_rd = 0; m_wr = 0; m_hit = 0;
        chk_counts("t1");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; req_valid = 2'b00; c_done = 1'b1; c_hit = 1'b1;
        @(negedge clk);
        c_done = 1'b0;
        #1;
        chk("t1_late_done_rsp", rsp_valid, 0);
        chk("t1_late_done_c_valid", c_valid, 0);
        @(negedge clk);
        #1;
        chk("t1_late_done_rsp2", rsp_valid, 0);
        chk_counts("t1_late");

        // Round-robin with both requesters held valid
        run_txn(2'b11, 2'b00, 32'h100, 32'h200, 0, 0, 1'b0, 1'b0, 0);
        run_txn(2'b11, 2'b00, 32'h104, 32'h204, 0, 0, 1'b0, 1'b0, 1);
        run_txn(2'b11, 2'b00, 32'h108, 32'h208, 0, 0, 1'b1, 1'b0, 0);
        run_txn(2'b11, 2'b00, 32'h10C, 32'h20C, 0, 0, 1'b1, 1'b0, 1);

        // Backpressure: five cycles of c_ready low
        run_txn(2'b01, 2'b01, 32'hDEAD_BEE0, 32'h0, 5, 1, 1'b0, 1'b0, 0);

        // Write miss from requester 1
        run_txn(2'b10, 2'b10, 32'h0, 32'h0000_2000, 0, 0, 1'b0, 1'b0, 1);
        idle_cycle();

        // Randomized traffic against the model
        do_reset();
        for (int t = 0; t < 12; t++) begin
            logic [N-1:0] mask;
            mask = N'($urandom_range(1, 3));
            run_txn(mask, N'($urandom), $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'b1, -1);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        // Saturation: 17 reads into a 4-bit counter
        do_reset();
        for (int t = 0; t < 17; t++) begin
            run_txn(2'b01, 2'b00, 32'h40 * t, 32'h0, 0, 0, 1'b0, 1'b0, 0);
        end
        idle_cycle();
        chk("t6_sat_reads", num_reads, 15);
        chk("t6_writes", num_writes, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
